// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and the load unit for a single register-file
// write port, with a pending-load scoreboard that drives the decode stall.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [2:0]  ld_type,
    input  logic        issue_ld,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rs_b,
    output logic        stall,
    output logic [2:0]  rwe,
    output logic [4:0]  Addr_D,
    output logic [31:0] Data_D
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef struct packed {
        logic [2:0]  rwe;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] busy_q, busy_d;
    wb_t         wb_q, wb_d;

    logic        starve_hit;
    logic        alu_acc;
    logic        ld_acc;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    // Unknown or reserved load types fall back to a full-word write.
    function automatic logic [2:0] ld_rwe(input logic [2:0] t);
        logic [2:0] r;
        r = 3'd1;
        if (t >= 3'd1 && t <= 3'd5) r = t;
        return r;
    endfunction

    // Readies go low while reset is held so nothing is consumed during reset.
    assign starve_hit = (starve_cnt_q == STARVE_LIM);
    assign alu_ready  = reset & alu_valid & (~ld_valid | starve_hit);
    assign ld_ready   = reset & ld_valid & ~(alu_valid & starve_hit);
    assign alu_acc    = alu_valid & alu_ready;
    assign ld_acc     = ld_valid & ld_ready;

    always_comb begin
        wb_d = '0;
        if (alu_acc) begin
            if (alu_rd != 5'd0) begin
                wb_d.rwe  = 3'd1;
                wb_d.addr = alu_rd;
                wb_d.data = alu_data;
            end
        end else if (ld_acc) begin
            if (ld_rd != 5'd0) begin
                wb_d.rwe  = ld_rwe(ld_type);
                wb_d.addr = ld_rd;
                wb_d.data = ld_data;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_acc)
            starve_cnt_d = 4'd0;
        else if (alu_valid && !alu_ready && starve_cnt_q < STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Set wins over clear so a reissued load to the same register stays pending.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_ld) busy_set[issue_rd] = 1'b1;
        if (ld_acc)   busy_clr[ld_rd]    = 1'b1;
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    assign stall = ((rs_a != 5'd0) & busy_q[rs_a]) | ((rs_b != 5'd0) & busy_q[rs_b]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q         <= '0;
            starve_cnt_q <= 4'd0;
            busy_q       <= '0;
        end else begin
            wb_q         <= wb_d;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign rwe    = wb_q.rwe;
    assign Addr_D = wb_q.addr;
    assign Data_D = wb_q.data;

endmodule
